// File: rtl/fp_addsub_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_seq_if
//  Brief    : Operand/result handshake bundle for the sequential FP add/sub.
//  Revision : 1.0
// ============================================================================
interface fp_addsub_seq_if #(
    parameter int EXPONENT = 8,
    parameter int FRACTION = 23
);
    localparam int WIDTH = 1 + EXPONENT + FRACTION;

    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] num_a;
    logic [WIDTH-1:0] num_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, op_sub, num_a, num_b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op_sub, num_a, num_b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_seq
//  Brief    : Multi-cycle FP adder/subtractor, RNE rounding, FTZ, status flags.
//  Revision : 1.0
// ============================================================================
module fp_addsub_seq #(
    parameter int EXPONENT = 8,
    parameter int FRACTION = 23
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    fp_addsub_seq_if.slave io_bus
);
    localparam int WIDTH = 1 + EXPONENT + FRACTION;
    localparam int c_MW  = FRACTION + 1;
    localparam int c_DW  = c_MW + 3;
    localparam int c_EW  = EXPONENT + 1;
    localparam logic [EXPONENT-1:0] c_EXP_ONES = '1;
    localparam logic [c_EW-1:0]     c_EXP_MAX  = {1'b0, c_EXP_ONES};
    localparam logic [WIDTH-1:0]    c_QNAN     = {1'b0, c_EXP_ONES, 1'b1, {(FRACTION-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_a, r_b;
    logic             r_sign, r_eff_sub;
    logic [c_EW-1:0]  r_exp;
    logic [c_DW-1:0]  r_mant_l, r_mant_s;
    logic [c_DW:0]    r_sum;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    // ---------------- unpack / special-value resolution ----------------
    logic                w_sa, w_sb;
    logic [EXPONENT-1:0] w_ea, w_eb;
    logic [FRACTION-1:0] w_fa, w_fb;
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic             w_special;
    logic [WIDTH-1:0] w_spec_res;
    logic [3:0]       w_spec_flg;

    assign {w_sa, w_ea, w_fa} = r_a;
    assign {w_sb, w_eb, w_fb} = r_b;
    assign w_a_nan  = (w_ea == c_EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_EXP_ONES) && (w_fb != '0);
    assign w_a_snan = w_a_nan && !w_fa[FRACTION-1];
    assign w_b_snan = w_b_nan && !w_fb[FRACTION-1];
    assign w_a_inf  = (w_ea == c_EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_EXP_ONES) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);

    // r_b already carries the effective sign (op_sub folded in at capture)
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
        w_spec_flg = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_res = c_QNAN;
            w_spec_flg = {(w_a_snan || w_b_snan), 3'b000};
        end else if (w_a_inf && w_b_inf) begin
            if (w_sa != w_sb) begin
                w_spec_res = c_QNAN;
                w_spec_flg = 4'b1000;
            end else begin
                w_spec_res = r_a;
            end
        end else if (w_a_inf) begin
            w_spec_res = r_a;
        end else if (w_b_inf) begin
            w_spec_res = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {(w_sa && w_sb), {(WIDTH-1){1'b0}}};
        end else if (w_a_zero) begin
            w_spec_res = r_b;
        end else if (w_b_zero) begin
            w_spec_res = r_a;
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- alignment ----------------
    logic                w_a_ge_b;
    logic [WIDTH-1:0]    w_l, w_s;
    logic [EXPONENT-1:0] w_diff;
    logic [c_DW-1:0]     w_ext_s, w_shifted, w_lost, w_aligned;

    assign w_a_ge_b  = (r_a[WIDTH-2:0] >= r_b[WIDTH-2:0]);
    assign w_l       = w_a_ge_b ? r_a : r_b;
    assign w_s       = w_a_ge_b ? r_b : r_a;
    assign w_diff    = w_l[WIDTH-2:FRACTION] - w_s[WIDTH-2:FRACTION];
    assign w_ext_s   = {1'b1, w_s[FRACTION-1:0], 3'b000};
    // Oversized shifts yield zero data and a full lost-mask, i.e. sticky only
    assign w_shifted = w_ext_s >> w_diff;
    assign w_lost    = w_ext_s & ~({c_DW{1'b1}} << w_diff);
    assign w_aligned = {w_shifted[c_DW-1:1], w_shifted[0] | (|w_lost)};

    // ---------------- normalise decisions ----------------
    logic w_norm_carry, w_sum_zero, w_norm_shift;
    assign w_norm_carry = r_sum[c_DW];
    assign w_sum_zero   = (r_sum == '0);
    assign w_norm_shift = !r_sum[c_DW-1] && (r_exp > c_EW'(1));

    // ---------------- rounding (RNE) ----------------
    logic [c_MW-1:0]     w_mant;
    logic                w_g, w_rnd_up, w_inexact;
    logic [c_MW:0]       w_mant_rnd;
    logic [c_EW-1:0]     w_exp_rnd;
    logic [FRACTION-1:0] w_frac_rnd;

    assign w_mant     = r_sum[c_DW-1:3];
    assign w_g        = r_sum[2];
    assign w_inexact  = |r_sum[2:0];
    assign w_rnd_up   = w_g && (r_sum[1] || r_sum[0] || w_mant[0]);
    assign w_mant_rnd = {1'b0, w_mant} + {{c_MW{1'b0}}, w_rnd_up};
    assign w_exp_rnd  = r_exp + {{EXPONENT{1'b0}}, w_mant_rnd[c_MW]};
    assign w_frac_rnd = w_mant_rnd[c_MW] ? w_mant_rnd[FRACTION:1] : w_mant_rnd[FRACTION-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (io_bus.in_valid) w_state_nxt = ST_UNPACK;
            ST_UNPACK: w_state_nxt = w_special ? ST_DONE : ST_ALIGN;
            ST_ALIGN:  w_state_nxt = ST_ADD;
            ST_ADD:    w_state_nxt = ST_NORM;
            ST_NORM: begin
                if (w_norm_carry)      w_state_nxt = ST_ROUND;
                else if (w_sum_zero)   w_state_nxt = ST_DONE;
                else if (w_norm_shift) w_state_nxt = ST_NORM;
                else                   w_state_nxt = ST_ROUND;
            end
            ST_ROUND:  w_state_nxt = ST_DONE;
            ST_DONE:   if (io_bus.out_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_exp     <= '0;
            r_mant_l  <= '0;
            r_mant_s  <= '0;
            r_sum     <= '0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_a <= io_bus.num_a;
                        r_b <= {io_bus.num_b[WIDTH-1] ^ io_bus.op_sub, io_bus.num_b[WIDTH-2:0]};
                    end
                end
                ST_UNPACK: begin
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_flags  <= w_spec_flg;
                    end
                end
                ST_ALIGN: begin
                    r_sign    <= w_l[WIDTH-1];
                    r_eff_sub <= w_l[WIDTH-1] ^ w_s[WIDTH-1];
                    r_exp     <= {1'b0, w_l[WIDTH-2:FRACTION]};
                    r_mant_l  <= {1'b1, w_l[FRACTION-1:0], 3'b000};
                    r_mant_s  <= w_aligned;
                end
                ST_ADD: begin
                    r_sum <= r_eff_sub ? ({1'b0, r_mant_l} - {1'b0, r_mant_s})
                                       : ({1'b0, r_mant_l} + {1'b0, r_mant_s});
                end
                ST_NORM: begin
                    if (w_norm_carry) begin
                        r_sum <= {1'b0, r_sum[c_DW:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + c_EW'(1);
                    end else if (w_sum_zero) begin
                        r_result <= '0;
                        r_flags  <= '0;
                    end else if (w_norm_shift) begin
                        r_sum <= {r_sum[c_DW-1:0], 1'b0};
                        r_exp <= r_exp - c_EW'(1);
                    end
                end
                ST_ROUND: begin
                    if (!r_sum[c_DW-1]) begin
                        r_result <= {r_sign, {(WIDTH-1){1'b0}}};
                        r_flags  <= 4'b0011;
                    end else if (w_exp_rnd >= c_EXP_MAX) begin
                        r_result <= {r_sign, c_EXP_ONES, {FRACTION{1'b0}}};
                        r_flags  <= 4'b0101;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[EXPONENT-1:0], w_frac_rnd};
                        r_flags  <= {3'b000, w_inexact};
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == ST_IDLE);
    assign io_bus.out_valid = (r_state == ST_DONE);
    assign io_bus.result    = r_result;
    assign io_bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_seq
//  Brief    : Directed-vector self-checking bench for fp_addsub_seq (FP32).
//  Revision : 1.0
// ============================================================================
module tb_fp_addsub_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp_addsub_seq_if #(.EXPONENT(8), .FRACTION(23)) bus ();

    fp_addsub_seq #(.EXPONENT(8), .FRACTION(23)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // exp_lat==0 means latency is not checked for this vector
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_res, input logic [3:0] exp_flg,
                          input int exp_lat, input bit hold, input bit early);
        int lat;
        int unstable;
        int rdy_seen;
        @(posedge clk); #1;
        check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.num_a     = a;
        bus.num_b     = b;
        bus.op_sub    = sub;
        bus.out_ready = early;
        lat = 1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.num_a    = '0;
        bus.num_b    = '0;
        bus.op_sub   = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            lat++;
            @(posedge clk); #1;
        end
        if (!bus.out_valid) begin
            check_val({tag, "_timeout"}, 32'(lat), 32'd0);
        end else begin
            if (exp_lat != 0) check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            check_val({tag, "_result"}, bus.result, exp_res);
            check_val({tag, "_flags"}, 32'(bus.flags), 32'(exp_flg));
            if (hold) begin
                unstable = 0;
                rdy_seen = 0;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (bus.result !== exp_res || bus.flags !== exp_flg || !bus.out_valid) unstable++;
                    if (bus.in_ready) rdy_seen++;
                end
                check_val({tag, "_hold_stable"}, 32'(unstable), 32'd0);
                check_val({tag, "_hold_in_ready"}, 32'(rdy_seen), 32'd0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check_val({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        int seen;
        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.num_a     = '0;
        bus.num_b     = '0;
        bus.out_ready = 1'b0;
        #23;
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_result",    bus.result,         32'h0);
        check_val("rst_flags",     32'(bus.flags),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 6, 1'b0, 1'b0);
        run_op("x_minus_x",    32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0000, 0, 1'b0, 1'b0);
        run_op("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 2, 1'b0, 1'b0);
        run_op("ovf_pos",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6, 1'b0, 1'b0);
        run_op("ovf_neg",      32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 4'b0101, 6, 1'b0, 1'b1);
        run_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6, 1'b1, 1'b0);
        run_op("tie_odd_up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 6, 1'b0, 1'b0);
        run_op("above_half",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, 6, 1'b0, 1'b0);
        run_op("grs_up",       32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 6, 1'b0, 1'b0);
        run_op("one_m_half",   32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000, 7, 1'b0, 1'b1);
        run_op("one_m_ulp",    32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, 7, 1'b0, 1'b0);
        run_op("snan",         32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2, 1'b0, 1'b0);
        run_op("qnan",         32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2, 1'b0, 1'b0);
        run_op("ninf_p_one",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 2, 1'b0, 1'b0);
        run_op("nz_p_nz",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2, 1'b0, 1'b0);
        run_op("two_p_ntwo",   32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 4'b0000, 0, 1'b0, 1'b0);
        run_op("underflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 6, 1'b0, 1'b0);

        // Abort a long normalisation with reset; nothing must come out
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.num_a    = 32'h3F800001;
        bus.num_b    = 32'h3F800000;
        bus.op_sub   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_val("abort_in_ready_rst", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_val("abort_no_out_valid", 32'(seen), 32'd0);
        check_val("abort_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("post_abort",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 6, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end
endmodule
`default_nettype wire
